// File: rtl/fft_helpers_stream_bit_reverse.sv
// Ping-pong reorder buffer: fills one bank in natural order while the other
// drains in bit-reversed (or natural) index order, one sample per cycle.
module fft_helpers_stream_bit_reverse #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [BIT_WIDTH-1:0]         recv_msg,
  input  logic                         recv_val,
  output logic                         recv_rdy,
  input  logic                         recv_rev,
  output logic [BIT_WIDTH-1:0]         send_msg,
  output logic                         send_val,
  input  logic                         send_rdy,
  output logic                         send_last,
  output logic [$clog2(N_SAMPLES)-1:0] send_idx
);

  localparam int IW = $clog2(N_SAMPLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_SAMPLES - 1);

  if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
    $error("N_SAMPLES must be a power of two >= 2");
  end

  logic [BIT_WIDTH-1:0] mem_q [2][N_SAMPLES];

  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;

  logic wr_fire, rd_fire, wr_end, rd_end;

  function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] a);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = a[IW-1-i];
    return r;
  endfunction

  assign recv_rdy  = !full_q[wr_bank_q];
  assign send_val  = full_q[rd_bank_q];
  assign send_idx  = mode_q[rd_bank_q] ? bit_rev(rd_idx_q) : rd_idx_q;
  assign send_msg  = mem_q[rd_bank_q][send_idx];
  assign send_last = send_val && (rd_idx_q == IDX_LAST);

  assign wr_fire = recv_val && recv_rdy;
  assign rd_fire = send_val && send_rdy;
  assign wr_end  = wr_fire && (wr_idx_q == IDX_LAST);
  assign rd_end  = rd_fire && (rd_idx_q == IDX_LAST);

  // Writer and reader always own different banks, so both updates may land.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == '0) mode_d[wr_bank_q] = recv_rev;
      if (wr_end) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end
    end
    if (rd_fire) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (rd_end) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_idx_d          = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q    <= '0;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_idx_q] <= recv_msg;
  end

endmodule

// File: tb/tb_fft_helpers_stream_bit_reverse.sv
// Randomized and directed bench for the streaming bit-reverse reorder unit,
// scored against a frame-level permutation model.
module tb_fft_helpers_stream_bit_reverse;

  localparam int BW = 32;
  localparam int N  = 8;
  localparam int L  = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [BW-1:0] recv_msg = '0;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic          recv_rev = 1'b0;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy = 1'b0;
  logic          send_last;
  logic [L-1:0]  send_idx;

  fft_helpers_stream_bit_reverse #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .recv_rev(recv_rev),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .send_last(send_last), .send_idx(send_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [BW-1:0] msg;
    int            idx;
    logic          last;
  } ent_t;

  ent_t          expq[$];
  logic [BW-1:0] part[$];
  logic          pmode;
  logic [BW-1:0] out_log[$];
  int            idx_log[$];
  logic          last_log[$];
  int            cyc_log[$];
  int            cyc = 0;
  int            stalls = 0;
  int            br8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int brev(input int j);
    int r = 0;
    int x = j;
    for (int k = 0; k < L; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Scoreboard: frames complete in the model, then drain in permuted order.
  initial begin
    logic          hold;
    logic [BW-1:0] hmsg;
    logic [L-1:0]  hidx;
    logic          hlast;
    ent_t          e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        part.delete();
        expq.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_val", send_val, 1);
          check("hold_msg", send_msg, hmsg);
          check("hold_idx", send_idx, hidx);
          check("hold_last", send_last, hlast);
        end
        hold  = send_val && !send_rdy;
        hmsg  = send_msg;
        hidx  = send_idx;
        hlast = send_last;
        if (send_val && send_rdy) begin
          check("sb_nonempty", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            check("out_msg", send_msg, e.msg);
            check("out_idx", send_idx, e.idx);
            check("out_last", send_last, e.last);
          end
          out_log.push_back(send_msg);
          idx_log.push_back(int'(send_idx));
          last_log.push_back(send_last);
          cyc_log.push_back(cyc);
        end
        if (recv_val && recv_rdy) begin
          if (part.size() == 0) pmode = recv_rev;
          part.push_back(recv_msg);
          if (part.size() == N) begin
            for (int j = 0; j < N; j++) begin
              e.idx  = pmode ? brev(j) : j;
              e.msg  = part[e.idx];
              e.last = (j == N - 1);
              expq.push_back(e);
            end
            part.delete();
          end
        end
      end
    end
  end

  task automatic push_sample(input logic [BW-1:0] m, input logic rev);
    logic ok;
    ok = 1'b0;
    recv_val = 1'b1;
    recv_msg = m;
    recv_rev = rev;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      ok = recv_rdy;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", ok, 1);
    recv_val = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int c = 0; c < 3000 && out_log.size() < n; c++) @(posedge clk);
    #1;
    check("nout", out_log.size(), n);
  endtask

  task automatic clear_logs();
    out_log.delete();
    idx_log.delete();
    last_log.delete();
    cyc_log.delete();
  endtask

  task automatic cmp_frame(input string tag, input int off, input int base,
                           input logic rev);
    for (int j = 0; j < N; j++)
      if (off + j < out_log.size())
        check(tag, out_log[off + j], base + (rev ? br8[j] : j));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_send_val", send_val, 0);
    check("rst_recv_rdy", recv_rdy, 1);
    check("rst_send_last", send_last, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: single reversed frame, latency and sideband
    send_rdy = 1'b1;
    clear_logs();
    for (int i = 0; i < N - 1; i++) push_sample(i, 1'b1);
    check("t1_pre", send_val, 0);
    push_sample(N - 1, 1'b1);
    check("t1_lat", send_val, 1);
    wait_out(8);
    cmp_frame("t1_msg", 0, 0, 1'b1);
    for (int j = 0; j < N; j++)
      if (j < idx_log.size()) begin
        check("t1_idx", idx_log[j], br8[j]);
        check("t1_last", last_log[j], j == N - 1);
      end

    // 2: three back-to-back frames, no bubbles
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    stalls = 0;
    for (int i = 0; i < 3 * N; i++) push_sample(i, 1'b1);
    wait_out(24);
    check("t2_stalls", stalls, 0);
    if (cyc_log.size() == 24) check("t2_span", cyc_log[23] - cyc_log[0], 23);
    for (int f = 0; f < 3; f++) cmp_frame("t2_msg", 8 * f, 8 * f, 1'b1);

    // 3: per-frame mode, mid-frame toggle ignored
    clear_logs();
    for (int i = 0; i < N; i++) push_sample(i, 1'b0);
    for (int i = 0; i < N; i++) push_sample(8 + i, i < 3);
    wait_out(16);
    cmp_frame("t3_a", 0, 0, 1'b0);
    cmp_frame("t3_b", 8, 8, 1'b1);

    // 4: backpressure fills both banks then stops
    clear_logs();
    send_rdy = 1'b0;
    recv_rev = 1'b1;
    begin
      int  acc;
      logic ok;
      acc = 0;
      recv_val = 1'b1;
      for (int c = 0; c < 20; c++) begin
        recv_msg = 200 + acc;
        @(negedge clk);
        ok = recv_rdy;
        @(posedge clk);
        #1;
        if (ok) acc++;
      end
      recv_val = 1'b0;
      check("t4_acc", acc, 16);
      check("t4_rdy_lo", recv_rdy, 0);
      send_rdy = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        ok = send_val && send_rdy && send_last;
        if (ok) check("t4_rdy_before", recv_rdy, 0);
      end
      check("t4_drain", ok, 1);
      @(posedge clk);
      #1;
      check("t4_rdy_after", recv_rdy, 1);
    end
    wait_out(16);
    cmp_frame("t4_a", 0, 200, 1'b1);
    cmp_frame("t4_b", 8, 208, 1'b1);

    // 5: random stalls, data and modes
    clear_logs();
    fork
      begin
        for (int f = 0; f < 50; f++) begin
          logic rv;
          rv = 1'(($urandom >> 3) & 1);
          for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            push_sample($urandom, (i == 0) ? rv : 1'(($urandom >> 5) & 1));
          end
        end
      end
      begin
        for (int c = 0; c < 20000 && out_log.size() < 50 * N; c++) begin
          send_rdy = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        send_rdy = 1'b1;
      end
    join
    wait_out(50 * N);
    check("t5_sb_empty", expq.size(), 0);

    // 6: async reset mid-fill and mid-drain
    send_rdy = 1'b0;
    for (int i = 0; i < N; i++) push_sample(50 + i, 1'b1);
    for (int i = 0; i < 5; i++) push_sample(60 + i, 1'b1);
    send_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_val", send_val, 0);
    check("t6_rdy", recv_rdy, 1);
    check("t6_last", send_last, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_logs();
    for (int i = 0; i < N; i++) push_sample(100 + i, 1'b1);
    wait_out(8);
    cmp_frame("t6_msg", 0, 100, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle", send_val, 0);
    check("t6_sb_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
